unpack_pipe: RTL and testbench
==============================

UNPACK_PIPE -- requirements
Module: unpack_pipe

Interface
REQ-001 SHALL have parameter NOPS, default 3, number of operand channels (1..4).
REQ-002 SHALL have parameter STEP, default 8, maximum normalization left-shift per cycle (1..NF+1).
REQ-003 SHALL take FLEN, NE, NF, FMTBITS, LOGFLEN from config_pkg.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock.
- resetn  in  1  reset; one clock, synchronous, active-low.
- Flush  in  1  kill in-flight operation.
- InValid  in  1  operand set offered.
- InReady  out  1  unit can accept.
- Fmt  in  FMTBITS  format.
- Op  in  NOPS x FLEN  raw operands.
- OpEn  in  NOPS  per-operand enable.
- NormEn  in  1  normalize subnormals.
- OutValid  out  1  result held.
- OutReady  in  1  consumer accepts.
- Sgn  out  NOPS  sign bits.
- Exp  out  NOPS x (NE+1)  signed biased exponent.
- Man  out  NOPS x (NF+1)  mantissa.
- NaN, SNaN, Zero, Inf, Subnorm  out  NOPS each  class flags of the input.
- Bias  out  NE-1  format bias.
- Nf  out  LOGFLEN  fraction bits.

Function
REQ-005 SHALL accept an operand set when InValid and InReady are high at a rising edge; InReady SHALL be high only in state IDLE.
REQ-006 SHALL use FSM states IDLE, NORM, DONE; reset state IDLE.
REQ-007 On accept, SHALL register Fmt, NormEn and the per-channel unpack (sign, exponent, mantissa, class flags, all widened to the largest format) for every channel.
REQ-008 On accept, SHALL go to NORM if NormEn=1 and any enabled channel is subnormal, otherwise to DONE.
REQ-009 Subnormal exponent SHALL be captured as +1; normal exponents SHALL be captured as the zero-extended biased value.
REQ-010 In each NORM cycle, every channel whose Man MSB is 0 and which is not Zero SHALL shift Man left by min(STEP, leading-zero count) and subtract the same amount from Exp, in NE+1-bit two's complement.
REQ-011 NORM SHALL go to DONE on the edge after which all such channels have Man MSB set.
REQ-012 Latency from the accept edge to OutValid SHALL be 1 + ceil(max leading zeros / STEP) cycles.
REQ-013 OutValid SHALL be high exactly in DONE.
REQ-014 All outputs SHALL be stable while OutValid=1 and OutReady=0.
REQ-015 DONE with OutReady=1 SHALL go to IDLE; a new accept SHALL NOT occur in that same cycle.
REQ-016 A channel with OpEn=0 SHALL output Sgn=0, Exp=0, Man=0 and all flags 0, and SHALL be ignored by REQ-008 and REQ-011.
REQ-017 Subnorm, NaN, SNaN, Zero and Inf SHALL reflect the input as accepted; normalization SHALL NOT alter them.
REQ-018 NaN/Inf channels SHALL pass through unchanged, with no shift.
REQ-019 Bias and Nf SHALL be derived from the registered Fmt.
REQ-020 Flush SHALL force IDLE and OutValid=0 on the next edge from any state, and SHALL override OutReady and InValid in the same cycle.

Reset
REQ-021 When resetn=0 at an edge: state SHALL be IDLE, OutValid=0, InReady=1, and all registered data SHALL be 0.
REQ-022 Reset during NORM or DONE SHALL abandon the operation with no output handshake.

Structure
REQ-023 The FSM state enum SHALL be local to the module; width constants SHALL come from config_pkg, with no new package.
REQ-024 Per-channel combinational unpacking SHALL use one instance of unpackinput per channel.
REQ-025 Leading-zero counting SHALL use the existing lzc block.
REQ-026 Bias and Nf SHALL be produced by fmtparams.

Verification
REQ-027 Double, Op0=0x3FF0000000000000, NormEn=1, others disabled: OutValid 1 cycle after accept; Exp0=1023, Man0=0x10000000000000.
REQ-028 Double, Op0=0x0000000000000001, STEP=8, NormEn=1: 7 NORM cycles, OutValid at accept+8; Exp0=-51, Man0 MSB set, Subnorm0=1.
REQ-029 Same stimulus as REQ-028 with NormEn=0: OutValid at accept+1; Exp0=1, Man0=1.
REQ-030 OutReady held 0 for 5 cycles in DONE: outputs unchanged and InReady=0 throughout; IDLE one cycle after OutReady=1.
REQ-031 Flush asserted on the 3rd NORM cycle of REQ-028: OutValid never rises; InReady=1 the next cycle.
REQ-032 resetn=0 during NORM: the next cycle has IDLE, OutValid=0 and all outputs 0.

Source files
------------

// File: rtl/config_pkg.sv
// config_pkg: shared floating-point widths (FLEN/NE/NF/FMTBITS/LOGFLEN) and format codes for the FP front end
package config_pkg;
  localparam int FLEN = 64;
  localparam int NE = 11;
  localparam int NF = 52;
  localparam int FMTBITS = 2;
  localparam int LOGFLEN = $clog2(FLEN);
  localparam logic [FMTBITS-1:0] FMT_S = 2'd0;
  localparam logic [FMTBITS-1:0] FMT_D = 2'd1;
  localparam logic [FMTBITS-1:0] FMT_H = 2'd2;
  localparam logic [FMTBITS-1:0] FMT_B = 2'd3;
endpackage

// File: rtl/unpack_pipe_if.sv
// unpack_pipe_if: operand-in/result-out bundle of unpack_pipe; master drives operands and out_ready, slave returns results
interface unpack_pipe_if import config_pkg::*; #(parameter int NOPS = 3);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [FMTBITS-1:0] fmt;
  logic [NOPS-1:0][FLEN-1:0] op;
  logic [NOPS-1:0] op_en;
  logic norm_en;
  logic out_valid;
  logic out_ready;
  logic [NOPS-1:0] sgn;
  logic [NOPS-1:0][NE:0] exp;
  logic [NOPS-1:0][NF:0] man;
  logic [NOPS-1:0] nan, snan, zero, inf, subnorm;
  logic [NE-2:0] bias;
  logic [LOGFLEN-1:0] nf;
  modport master (output flush, in_valid, fmt, op, op_en, norm_en, out_ready,
                  input in_ready, out_valid, sgn, exp, man, nan, snan, zero, inf, subnorm, bias, nf);
  modport slave (input flush, in_valid, fmt, op, op_en, norm_en, out_ready,
                 output in_ready, out_valid, sgn, exp, man, nan, snan, zero, inf, subnorm, bias, nf);
endinterface

// File: rtl/fmtparams.sv
// fmtparams: fmt in -> bias (NE-1 bits) and fraction width nf (LOGFLEN bits) of that format
module fmtparams import config_pkg::*; (
  input  logic [FMTBITS-1:0] fmt,
  output logic [NE-2:0]      bias,
  output logic [LOGFLEN-1:0] nf
);
  assign bias = fmt == FMT_S ? (NE-1)'(127) : fmt == FMT_H ? (NE-1)'(15) : fmt == FMT_B ? (NE-1)'(127) : (NE-1)'(1023);
  assign nf = fmt == FMT_S ? LOGFLEN'(23) : fmt == FMT_H ? LOGFLEN'(10) : fmt == FMT_B ? LOGFLEN'(7) : LOGFLEN'(52);
endmodule

// File: rtl/lzc.sv
// lzc: num in -> cnt = leading-zero count from the MSB (WIDTH when num is zero)
module lzc #(parameter int WIDTH = 53, parameter int CW = $clog2(WIDTH + 1)) (
  input  logic [WIDTH-1:0] num,
  output logic [CW-1:0]    cnt
);
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) if (num[i]) cnt = CW'(WIDTH - 1 - i);
  end
endmodule

// File: rtl/unpackinput.sv
// unpackinput: raw operand x, fmt, en in -> sign, widened exponent/mantissa and class flags (all zero when en=0)
module unpackinput import config_pkg::*; (
  input  logic [FLEN-1:0]    x,
  input  logic [FMTBITS-1:0] fmt,
  input  logic               en,
  output logic               sgn,
  output logic [NE:0]        exp,
  output logic [NF:0]        man,
  output logic               nan, snan, zero, inf, sub
);
  logic s, ez, eo, fz;
  logic [NE-1:0] e, emax;
  logic [NF-1:0] f;
  always_comb begin
    s = x[63];
    e = x[62:52];
    f = x[51:0];
    emax = '1;
    case (fmt)
      FMT_S: begin s = x[31]; e = {3'b0, x[30:23]}; f = {x[22:0], 29'b0}; emax = 11'h0ff; end
      FMT_H: begin s = x[15]; e = {6'b0, x[14:10]}; f = {x[9:0], 42'b0}; emax = 11'h01f; end
      FMT_B: begin s = x[15]; e = {3'b0, x[14:7]}; f = {x[6:0], 45'b0}; emax = 11'h0ff; end
      default: ;
    endcase
  end
  assign ez = e == '0;
  assign eo = e == emax;
  assign fz = f == '0;
  assign nan = en & eo & ~fz;
  assign snan = nan & ~f[NF-1];
  assign inf = en & eo & fz;
  assign zero = en & ez & fz;
  assign sub = en & ez & ~fz;
  assign sgn = en & s;
  assign exp = en ? (sub ? (NE+1)'(1) : {1'b0, e}) : '0;
  assign man = en ? {~ez, f} : '0;
endmodule

// File: rtl/unpack_pipe.sv
// unpack_pipe: accepts NOPS raw operands (InValid/InReady), unpacks and optionally normalizes subnormals STEP bits per cycle, holds result (OutValid/OutReady) with Bias/Nf of the format
module unpack_pipe import config_pkg::*; #(
  parameter int NOPS = 3,
  parameter int STEP = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      Flush,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [FMTBITS-1:0]        Fmt,
  input  logic [NOPS-1:0][FLEN-1:0] Op,
  input  logic [NOPS-1:0]           OpEn,
  input  logic                      NormEn,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [NOPS-1:0]           Sgn,
  output logic [NOPS-1:0][NE:0]     Exp,
  output logic [NOPS-1:0][NF:0]     Man,
  output logic [NOPS-1:0]           NaN,
  output logic [NOPS-1:0]           SNaN,
  output logic [NOPS-1:0]           Zero,
  output logic [NOPS-1:0]           Inf,
  output logic [NOPS-1:0]           Subnorm,
  output logic [NE-2:0]             Bias,
  output logic [LOGFLEN-1:0]        Nf
);
  localparam int LW = $clog2(NF + 2);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t state, nxt;
  logic [FMTBITS-1:0] fmt_q;
  logic norm_q, acc, need;
  logic [NOPS-1:0] en_q, act, fin;
  logic [NOPS-1:0] u_sgn, u_nan, u_snan, u_zero, u_inf, u_sub;
  logic [NOPS-1:0][NE:0] u_exp, exp_n;
  logic [NOPS-1:0][NF:0] u_man, man_n;
  logic [NOPS-1:0][LW-1:0] lz, sh;
  logic [NE-2:0] bias_f;
  logic [LOGFLEN-1:0] nf_f;
  for (genvar i = 0; i < NOPS; i++) begin : g_ch
    unpackinput u_unp (
      .x(Op[i]), .fmt(Fmt), .en(OpEn[i]), .sgn(u_sgn[i]), .exp(u_exp[i]), .man(u_man[i]),
      .nan(u_nan[i]), .snan(u_snan[i]), .zero(u_zero[i]), .inf(u_inf[i]), .sub(u_sub[i])
    );
    lzc #(.WIDTH(NF + 1)) u_lzc (.num(Man[i]), .cnt(lz[i]));
    // only enabled, unnormalized, finite non-zero channels move; NaN/Inf always carry the hidden one
    assign act[i] = norm_q & en_q[i] & ~Man[i][NF] & ~Zero[i] & ~NaN[i] & ~Inf[i];
    assign sh[i] = act[i] ? (lz[i] > LW'(STEP) ? LW'(STEP) : lz[i]) : '0;
    assign man_n[i] = Man[i] << sh[i];
    assign exp_n[i] = Exp[i] - {{(NE + 1 - LW){1'b0}}, sh[i]};
    // channel is normalized once this cycle's shift lands its MSB
    assign fin[i] = ~act[i] | (lz[i] <= LW'(STEP));
  end
  fmtparams u_fp (.fmt(fmt_q), .bias(bias_f), .nf(nf_f));
  assign acc = state == IDLE & InValid & ~Flush;
  assign need = NormEn & |(OpEn & u_sub);
  assign InReady = state == IDLE;
  assign OutValid = state == DONE;
  assign Bias = state == IDLE ? '0 : bias_f;
  assign Nf = state == IDLE ? '0 : nf_f;
  always_comb begin
    nxt = state;
    if (state == IDLE && InValid) nxt = need ? NORM : DONE;
    if (state == NORM && &fin) nxt = DONE;
    if (state == DONE && OutReady) nxt = IDLE;
    if (Flush) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      fmt_q <= '0;
      norm_q <= 1'b0;
      en_q <= '0;
      Sgn <= '0;
      Exp <= '0;
      Man <= '0;
      NaN <= '0;
      SNaN <= '0;
      Zero <= '0;
      Inf <= '0;
      Subnorm <= '0;
    end else begin
      state <= nxt;
      if (acc) begin
        fmt_q <= Fmt;
        norm_q <= NormEn;
        en_q <= OpEn;
        Sgn <= u_sgn;
        Exp <= u_exp;
        Man <= u_man;
        NaN <= u_nan;
        SNaN <= u_snan;
        Zero <= u_zero;
        Inf <= u_inf;
        Subnorm <= u_sub;
      end else if (state == NORM) begin
        Exp <= exp_n;
        Man <= man_n;
      end
    end
  end
endmodule

// File: tb/tb_unpack_pipe.sv
// tb_unpack_pipe: directed checks plus randomized scoreboard run of unpack_pipe against a bit-serial reference model
module tb_unpack_pipe;
  import config_pkg::*;
  localparam int NOPS = 3;
  localparam int STEP = 8;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  unpack_pipe_if #(.NOPS(NOPS)) bus();
  unpack_pipe #(.NOPS(NOPS), .STEP(STEP)) dut (
    .clk(clk), .resetn(resetn), .Flush(bus.flush), .InValid(bus.in_valid), .InReady(bus.in_ready),
    .Fmt(bus.fmt), .Op(bus.op), .OpEn(bus.op_en), .NormEn(bus.norm_en), .OutValid(bus.out_valid),
    .OutReady(bus.out_ready), .Sgn(bus.sgn), .Exp(bus.exp), .Man(bus.man), .NaN(bus.nan),
    .SNaN(bus.snan), .Zero(bus.zero), .Inf(bus.inf), .Subnorm(bus.subnorm), .Bias(bus.bias), .Nf(bus.nf)
  );
  typedef struct {
    logic [NOPS-1:0] sgn, nan, snan, zero, inf, sub;
    logic [NOPS-1:0][NE:0] exp;
    logic [NOPS-1:0][NF:0] man;
    logic [NE-2:0] bias;
    logic [LOGFLEN-1:0] nf;
    int lat;
    int acc;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0;
  bit mon_en = 0, seen = 0, drv_done = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask
  function automatic int fne(int f);
    return f == 0 ? 8 : f == 1 ? 11 : f == 2 ? 5 : 8;
  endfunction
  function automatic int fnf(int f);
    return f == 0 ? 23 : f == 1 ? 52 : f == 2 ? 10 : 7;
  endfunction
  // class: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 quiet NaN, 5 signaling NaN
  task automatic gen_ch(input int f, input int cls, output logic [63:0] x, output logic [63:0] s,
                        output logic [63:0] e, output logic [63:0] fr);
    int ne, nf;
    logic [63:0] emax;
    ne = fne(f);
    nf = fnf(f);
    emax = (64'd1 << ne) - 1;
    s = 64'($urandom_range(0, 1));
    fr = {$urandom, $urandom} & ((64'd1 << nf) - 1);
    e = 0;
    case (cls)
      0: fr = 0;
      1: begin fr = fr >> $urandom_range(0, nf - 1); if (fr == 0) fr = 1; end
      2: e = 64'($urandom_range(1, int'(emax) - 1));
      3: begin e = emax; fr = 0; end
      4: begin e = emax; fr = fr | (64'd1 << (nf - 1)); end
      default: begin e = emax; fr = fr & ~(64'd1 << (nf - 1)); if (fr == 0) fr = 1; end
    endcase
    x = (s << (ne + nf)) | (e << nf) | fr;
    if (ne + nf + 1 < 64) x = x | (~64'd0 << (ne + nf + 1));
  endtask
  task automatic set_in(input logic [1:0] f, input logic [63:0] o0, input logic [63:0] o1,
                        input logic [63:0] o2, input logic [2:0] en, input logic ne);
    bus.fmt = f;
    bus.op[0] = o0;
    bus.op[1] = o1;
    bus.op[2] = o2;
    bus.op_en = en;
    bus.norm_en = ne;
  endtask
  task automatic start(input string name, input logic [1:0] f, input logic [63:0] o0, input logic [63:0] o1,
                       input logic [2:0] en, input logic ne);
    @(negedge clk);
    set_in(f, o0, o1, 64'hFFF0_0000_0000_0000, en, ne);
    bus.in_valid = 1'b1;
    chk({name, " in_ready at offer"}, bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic take(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk({name, " idle after take"}, {bus.in_ready, bus.out_valid}, 2'b10);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && resetn && bus.out_valid) begin
      chk("result expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        if (!seen) begin
          chk("latency", cyc - sb[0].acc + 1, sb[0].lat);
          seen = 1;
        end
        if (bus.out_ready) begin
          e = sb.pop_front();
          seen = 0;
          chk("sgn", bus.sgn, e.sgn);
          chk("exp", bus.exp, e.exp);
          chk("man", bus.man, e.man);
          chk("flags", {bus.nan, bus.snan, bus.zero, bus.inf, bus.subnorm}, {e.nan, e.snan, e.zero, e.inf, e.sub});
          chk("bias", bus.bias, e.bias);
          chk("nf", bus.nf, e.nf);
        end
      end
    end
  end
  initial begin
    int lat, hit;
    logic [NOPS-1:0][NF:0] man_s;
    logic [NOPS-1:0][NE:0] exp_s;
    bus.flush = 0;
    bus.in_valid = 0;
    bus.out_ready = 0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset handshake", {bus.in_ready, bus.out_valid}, 2'b10);
    chk("reset data", {bus.exp, bus.man, bus.sgn, bus.subnorm, bus.bias, bus.nf}, 0);
    resetn = 1;
    start("one", 1, 64'h3FF0_0000_0000_0000, 0, 3'b001, 1);
    wait_valid(lat);
    chk("one latency", lat, 1);
    chk("one exp0", bus.exp[0], 12'd1023);
    chk("one man0", bus.man[0], 53'h10_0000_0000_0000);
    chk("one bias/nf", {bus.bias, bus.nf}, {10'd1023, 6'd52});
    take("one");
    start("tiny", 1, 64'h1, 64'h4000_0000_0000_0000, 3'b001, 1);
    wait_valid(lat);
    chk("tiny latency", lat, 8);
    chk("tiny exp0", bus.exp[0], 12'hFCD);
    chk("tiny man0", bus.man[0], 53'h10_0000_0000_0000);
    chk("tiny subnorm0", bus.subnorm[0], 1);
    chk("disabled channels", {bus.exp[2], bus.exp[1], bus.man[2], bus.man[1], bus.sgn[2:1], bus.zero[2:1]}, 0);
    man_s = bus.man;
    exp_s = bus.exp;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall outputs", {bus.man, bus.exp}, {man_s, exp_s});
      chk("stall handshake", {bus.in_ready, bus.out_valid}, 2'b01);
    end
    take("stall");
    start("nonorm", 1, 64'h1, 0, 3'b001, 0);
    wait_valid(lat);
    chk("nonorm latency", lat, 1);
    chk("nonorm exp0/man0", {bus.exp[0], bus.man[0]}, {12'd1, 53'd1});
    take("nonorm");
    start("lz8", 1, 0, 64'h1 << 44, 3'b010, 1);
    wait_valid(lat);
    chk("lz8 latency", lat, 2);
    chk("lz8 exp1/man1", {bus.exp[1], bus.man[1]}, {12'hFF9, 53'h10_0000_0000_0000});
    take("lz8");
    start("lz9", 1, 0, 64'h1 << 43, 3'b010, 1);
    wait_valid(lat);
    chk("lz9 latency", lat, 3);
    chk("lz9 exp1", bus.exp[1], 12'hFF8);
    take("lz9");
    start("flush", 1, 64'h1, 0, 3'b001, 1);
    repeat (2) @(posedge clk);
    #1 bus.flush = 1;
    @(posedge clk);
    #1 bus.flush = 0;
    chk("flush handshake", {bus.in_ready, bus.out_valid}, 2'b10);
    hit = 0;
    repeat (10) begin
      @(posedge clk);
      #1 hit += int'(bus.out_valid);
    end
    chk("no valid after flush", hit, 0);
    @(negedge clk);
    set_in(1, 64'h3FF0_0000_0000_0000, 0, 0, 3'b001, 0);
    bus.in_valid = 1;
    bus.flush = 1;
    @(posedge clk);
    #1 bus.in_valid = 0;
    bus.flush = 0;
    chk("flush beats in_valid", {bus.in_ready, bus.out_valid}, 2'b10);
    start("rst", 1, 64'h1, 0, 3'b001, 1);
    @(posedge clk);
    #1 resetn = 0;
    @(posedge clk);
    #1;
    chk("rst in norm handshake", {bus.in_ready, bus.out_valid}, 2'b10);
    chk("rst in norm data", {bus.exp, bus.man, bus.sgn, bus.subnorm, bus.bias, bus.nf}, 0);
    resetn = 1;
    mon_en = 1;
    fork
      begin
        for (int t = 0; t < 150; t++) begin
          exp_t e;
          logic [63:0] x, s, ev, fr;
          int f, nf, k, maxlz, lz;
          logic [2:0] en;
          logic ne;
          int cls_tab[9] = '{0, 1, 1, 1, 2, 2, 3, 4, 5};
          f = $urandom_range(0, 3);
          nf = fnf(f);
          en = 3'($urandom_range(0, 7));
          ne = $urandom_range(0, 3) != 0;
          e = '{default: '0};
          for (int c = 0; c < NOPS; c++) begin
            int cls;
            cls = cls_tab[$urandom_range(0, 8)];
            gen_ch(f, cls, x, s, ev, fr);
            bus.op[c] = x;
            if (en[c]) begin
              e.sgn[c] = s[0];
              e.zero[c] = cls == 0;
              e.sub[c] = cls == 1;
              e.inf[c] = cls == 3;
              e.nan[c] = cls >= 4;
              e.snan[c] = cls == 5;
              e.exp[c] = cls == 1 ? 12'd1 : 12'(ev);
              e.man[c] = (ev != 0 ? 53'h10_0000_0000_0000 : 53'd0) | 53'(fr << (52 - nf));
            end
          end
          maxlz = 0;
          if (ne && |(en & e.sub))
            for (int c = 0; c < NOPS; c++)
              if (e.sub[c]) begin
                lz = 0;
                while (!e.man[c][52]) begin
                  e.man[c] = e.man[c] << 1;
                  lz++;
                end
                e.exp[c] = e.exp[c] - 12'(lz);
                if (lz > maxlz) maxlz = lz;
              end
          e.lat = 1 + (maxlz + STEP - 1) / STEP;
          e.bias = 10'((1 << (fne(f) - 1)) - 1);
          e.nf = 6'(nf);
          @(negedge clk);
          bus.fmt = 2'(f);
          bus.op_en = en;
          bus.norm_en = ne;
          bus.in_valid = 1;
          k = 0;
          while (!bus.in_ready && k < 500) begin
            @(negedge clk);
            k++;
          end
          chk("accept wait", k < 500, 1);
          if (k < 500) begin
            e.acc = cyc + 1;
            sb.push_back(e);
          end
          @(posedge clk);
          #1 bus.in_valid = 0;
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        for (int k = 0; k < 2000 && sb.size() != 0; k++) @(posedge clk);
        drv_done = 1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #2 bus.out_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    chk("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
